// File: rtl/bp_fe_mem_1rw_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bp_fe_mem_1rw_arbiter_if                                                 |
// | Requester and SRAM-side bus bundle for the 1rw front-end memory arbiter. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface bp_fe_mem_1rw_arbiter_if #(
    parameter int width_p = 96,
    parameter int els_p   = 64
);
    localparam int addr_width_lp = $clog2(els_p);

    logic                     r0_v_i;
    logic                     r0_ready_o;
    logic                     r0_w_i;
    logic [addr_width_lp-1:0] r0_addr_i;
    logic [width_p-1:0]       r0_data_i;
    logic [width_p-1:0]       r0_w_mask_i;
    logic                     r0_v_o;
    logic [width_p-1:0]       r0_data_o;

    logic                     r1_v_i;
    logic                     r1_ready_o;
    logic                     r1_w_i;
    logic [addr_width_lp-1:0] r1_addr_i;
    logic [width_p-1:0]       r1_data_i;
    logic [width_p-1:0]       r1_w_mask_i;
    logic                     r1_v_o;
    logic [width_p-1:0]       r1_data_o;

    logic                     mem_v_o;
    logic                     mem_w_o;
    logic [addr_width_lp-1:0] mem_addr_o;
    logic [width_p-1:0]       mem_data_o;
    logic [width_p-1:0]       mem_w_mask_o;
    logic [width_p-1:0]       mem_data_i;

    // Arbiter side.
    modport slave (
        input  r0_v_i, r0_w_i, r0_addr_i, r0_data_i, r0_w_mask_i,
        output r0_ready_o, r0_v_o, r0_data_o,
        input  r1_v_i, r1_w_i, r1_addr_i, r1_data_i, r1_w_mask_i,
        output r1_ready_o, r1_v_o, r1_data_o,
        output mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_w_mask_o,
        input  mem_data_i
    );

    // Requesters plus SRAM wrapper side.
    modport master (
        output r0_v_i, r0_w_i, r0_addr_i, r0_data_i, r0_w_mask_i,
        input  r0_ready_o, r0_v_o, r0_data_o,
        output r1_v_i, r1_w_i, r1_addr_i, r1_data_i, r1_w_mask_i,
        input  r1_ready_o, r1_v_o, r1_data_o,
        input  mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_w_mask_o,
        output mem_data_i
    );
endinterface
`default_nettype wire

// File: rtl/bp_fe_mem_1rw_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bp_fe_mem_1rw_arbiter                                                    |
// | Two-requester arbiter with post-reset init sweep for a 1rw masked SRAM.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module bp_fe_mem_1rw_arbiter #(
    parameter int                 width_p        = 96,
    parameter int                 els_p          = 64,
    parameter int                 starve_limit_p = 4,
    parameter logic [width_p-1:0] init_val_p     = '0
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    output logic                         init_done_o,
    bp_fe_mem_1rw_arbiter_if.slave       bus
);
    localparam int addr_width_lp = $clog2(els_p);
    localparam int starve_w_lp   = $clog2(starve_limit_p + 1);
    localparam logic [addr_width_lp-1:0] c_last_addr    = addr_width_lp'(els_p - 1);
    localparam logic [starve_w_lp-1:0]   c_starve_limit = starve_w_lp'(starve_limit_p);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_INIT  = 2'd1,
        S_RUN   = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [addr_width_lp-1:0] init_cnt_q, init_cnt_d;
    logic [starve_w_lp-1:0]   starve_cnt_q, starve_cnt_d;
    logic                     r0_v_q, r0_v_d;
    logic                     r1_v_q, r1_v_d;

    logic                     w_starve;
    logic                     w_r0_ready, w_r1_ready;
    logic                     w_grant0, w_grant1;
    logic                     w_mem_v, w_mem_w;
    logic [addr_width_lp-1:0] w_mem_addr;
    logic [width_p-1:0]       w_mem_data, w_mem_mask;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= S_RESET;
            init_cnt_q   <= '0;
            starve_cnt_q <= '0;
            r0_v_q       <= 1'b0;
            r1_v_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            r0_v_q       <= r0_v_d;
            r1_v_q       <= r1_v_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        starve_cnt_d = starve_cnt_q;
        r0_v_d       = 1'b0;
        r1_v_d       = 1'b0;
        w_starve     = 1'b0;
        w_r0_ready   = 1'b0;
        w_r1_ready   = 1'b0;
        w_grant0     = 1'b0;
        w_grant1     = 1'b0;
        w_mem_v      = 1'b0;
        w_mem_w      = 1'b0;
        w_mem_addr   = '0;
        w_mem_data   = '0;
        w_mem_mask   = '0;

        case (state_q)
            S_RESET: begin
                state_d = S_INIT;
            end
            S_INIT: begin
                w_mem_v    = 1'b1;
                w_mem_w    = 1'b1;
                w_mem_addr = init_cnt_q;
                w_mem_data = init_val_p;
                w_mem_mask = '1;
                init_cnt_d = init_cnt_q + addr_width_lp'(1);
                if (init_cnt_q == c_last_addr) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // r0 wins by default; r1 takes the slot once it has lost starve_limit_p times in a row.
                w_starve   = (starve_cnt_q == c_starve_limit);
                w_r0_ready = !(bus.r1_v_i && w_starve);
                w_r1_ready = !bus.r0_v_i || w_starve;
                w_grant0   = bus.r0_v_i && w_r0_ready;
                w_grant1   = bus.r1_v_i && w_r1_ready;

                if (w_grant1) begin
                    w_mem_v    = 1'b1;
                    w_mem_w    = bus.r1_w_i;
                    w_mem_addr = bus.r1_addr_i;
                    w_mem_data = bus.r1_data_i;
                    w_mem_mask = bus.r1_w_mask_i;
                end else if (w_grant0) begin
                    w_mem_v    = 1'b1;
                    w_mem_w    = bus.r0_w_i;
                    w_mem_addr = bus.r0_addr_i;
                    w_mem_data = bus.r0_data_i;
                    w_mem_mask = bus.r0_w_mask_i;
                end

                r0_v_d = w_grant0 && !bus.r0_w_i;
                r1_v_d = w_grant1 && !bus.r1_w_i;

                if (w_grant1 || !bus.r1_v_i) begin
                    starve_cnt_d = '0;
                end else if (w_grant0 && (starve_cnt_q != c_starve_limit)) begin
                    starve_cnt_d = starve_cnt_q + starve_w_lp'(1);
                end
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    assign init_done_o      = (state_q == S_RUN);
    assign bus.r0_ready_o   = w_r0_ready;
    assign bus.r1_ready_o   = w_r1_ready;
    assign bus.r0_v_o       = r0_v_q;
    assign bus.r1_v_o       = r1_v_q;
    assign bus.r0_data_o    = bus.mem_data_i;
    assign bus.r1_data_o    = bus.mem_data_i;
    assign bus.mem_v_o      = w_mem_v;
    assign bus.mem_w_o      = w_mem_w;
    assign bus.mem_addr_o   = w_mem_addr;
    assign bus.mem_data_o   = w_mem_data;
    assign bus.mem_w_mask_o = w_mem_mask;
endmodule
`default_nettype wire

// File: tb/tb_bp_fe_mem_1rw_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bp_fe_mem_1rw_arbiter                                                 |
// | Directed vector bench with a behavioural masked 1rw SRAM.                |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_bp_fe_mem_1rw_arbiter;
    localparam int W = 96;
    localparam int N = 64;
    localparam logic [W-1:0] ALL = {W{1'b1}};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic init_done;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    bp_fe_mem_1rw_arbiter_if #(.width_p(W), .els_p(N)) ifc ();

    bp_fe_mem_1rw_arbiter #(
        .width_p(W), .els_p(N), .starve_limit_p(4), .init_val_p('0)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n), .init_done_o(init_done), .bus(ifc.slave)
    );

    // Masked SRAM with one-cycle read latency, preloaded with junk so the sweep matters.
    logic [W-1:0] sram [N];
    logic [W-1:0] rd_q = '0;
    initial for (int i = 0; i < N; i++) sram[i] = {3{32'hDEAD_0000 | 32'(i)}};
    always @(posedge clk) begin
        if (ifc.mem_v_o) begin
            if (ifc.mem_w_o)
                sram[ifc.mem_addr_o] <= (sram[ifc.mem_addr_o] & ~ifc.mem_w_mask_o) |
                                        (ifc.mem_data_o & ifc.mem_w_mask_o);
            else
                rd_q <= sram[ifc.mem_addr_o];
        end
    end
    assign ifc.mem_data_i = rd_q;

    typedef struct {
        string        name;
        logic         r0v, r0w; logic [5:0] r0a; logic [W-1:0] r0d, r0m;
        logic         r1v, r1w; logic [5:0] r1a; logic [W-1:0] r1d, r1m;
        logic         e_r0rdy, e_r1rdy, e_mv, e_mw; logic [5:0] e_ma;
        logic         e_r0v, e_r1v; logic [W-1:0] e_rd;
    } vec_t;

    vec_t vecs [12];

    function automatic vec_t mk(input string name,
        input logic r0v, input logic r0w, input logic [5:0] r0a, input logic [W-1:0] r0d, input logic [W-1:0] r0m,
        input logic r1v, input logic r1w, input logic [5:0] r1a, input logic [W-1:0] r1d, input logic [W-1:0] r1m,
        input logic er0r, input logic er1r, input logic emv, input logic emw, input logic [5:0] ema,
        input logic er0v, input logic er1v, input logic [W-1:0] erd);
        vec_t v;
        v.name = name;
        v.r0v = r0v; v.r0w = r0w; v.r0a = r0a; v.r0d = r0d; v.r0m = r0m;
        v.r1v = r1v; v.r1w = r1w; v.r1a = r1a; v.r1d = r1d; v.r1m = r1m;
        v.e_r0rdy = er0r; v.e_r1rdy = er1r; v.e_mv = emv; v.e_mw = emw; v.e_ma = ema;
        v.e_r0v = er0v; v.e_r1v = er1v; v.e_rd = erd;
        return v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r0v, input logic r0w, input logic [5:0] r0a, input logic [W-1:0] r0d,
                         input logic [W-1:0] r0m, input logic r1v, input logic r1w, input logic [5:0] r1a,
                         input logic [W-1:0] r1d, input logic [W-1:0] r1m);
        ifc.r0_v_i = r0v; ifc.r0_w_i = r0w; ifc.r0_addr_i = r0a; ifc.r0_data_i = r0d; ifc.r0_w_mask_i = r0m;
        ifc.r1_v_i = r1v; ifc.r1_w_i = r1w; ifc.r1_addr_i = r1a; ifc.r1_data_i = r1d; ifc.r1_w_mask_i = r1m;
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        drive(v.r0v, v.r0w, v.r0a, v.r0d, v.r0m, v.r1v, v.r1w, v.r1a, v.r1d, v.r1m);
        #1;
        check({v.name, ".r0_ready"}, W'(ifc.r0_ready_o), W'(v.e_r0rdy));
        check({v.name, ".r1_ready"}, W'(ifc.r1_ready_o), W'(v.e_r1rdy));
        check({v.name, ".mem_v"}, W'(ifc.mem_v_o), W'(v.e_mv));
        if (v.e_mv) begin
            check({v.name, ".mem_w"}, W'(ifc.mem_w_o), W'(v.e_mw));
            check({v.name, ".mem_addr"}, W'(ifc.mem_addr_o), W'(v.e_ma));
        end
        @(posedge clk); #1;
        check({v.name, ".r0_v_o"}, W'(ifc.r0_v_o), W'(v.e_r0v));
        check({v.name, ".r1_v_o"}, W'(ifc.r1_v_o), W'(v.e_r1v));
        if (v.e_r0v) check({v.name, ".r0_data"}, ifc.r0_data_o, v.e_rd);
        if (v.e_r1v) check({v.name, ".r1_data"}, ifc.r1_data_o, v.e_rd);
    endtask

    // Requests are held valid during reset and sweep to show they are ignored.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 6'd3, '0, '0, 1'b1, 1'b1, 6'd4, ALL, ALL);
        #1;
        check("rst.mem_v", W'(ifc.mem_v_o), '0);
        check("rst.r0_ready", W'(ifc.r0_ready_o), '0);
        check("rst.r1_ready", W'(ifc.r1_ready_o), '0);
        check("rst.init_done", W'(init_done), '0);
        check("rst.r0_v_o", W'(ifc.r0_v_o), '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel.mem_v", W'(ifc.mem_v_o), '0);
        check("rel.r1_ready", W'(ifc.r1_ready_o), '0);
    endtask

    task automatic run_sweep(input int stop_at);
        for (int i = 0; i < N; i++) begin
            @(posedge clk); #1;
            check("sweep.mem_v", W'(ifc.mem_v_o), W'(1));
            check("sweep.mem_w", W'(ifc.mem_w_o), W'(1));
            check("sweep.addr", W'(ifc.mem_addr_o), W'(i));
            check("sweep.mask", ifc.mem_w_mask_o, ALL);
            check("sweep.data", ifc.mem_data_o, '0);
            check("sweep.ready", W'({ifc.r0_ready_o, ifc.r1_ready_o}), '0);
            check("sweep.init_done", W'(init_done), '0);
            if (i == stop_at) return;
            if (i == N - 1) drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
        end
        @(posedge clk); #1;
        check("sweep.done", W'(init_done), W'(1));
        check("sweep.no_resp", W'({ifc.r0_v_o, ifc.r1_v_o}), '0);
    endtask

    // Both ports read every cycle: r1 wins on every fifth cycle.
    task automatic starve_seq(input string tag);
        for (int k = 0; k < 10; k++) begin
            logic r1win;
            r1win = ((k % 5) == 4);
            @(negedge clk);
            drive(1'b1, 1'b0, 6'd9, '0, '0, 1'b1, 1'b0, 6'd5, '0, '0);
            #1;
            check({tag, ".r0_ready"}, W'(ifc.r0_ready_o), W'(!r1win));
            check({tag, ".r1_ready"}, W'(ifc.r1_ready_o), W'(r1win));
            check({tag, ".addr"}, W'(ifc.mem_addr_o), r1win ? W'(5) : W'(9));
            @(posedge clk); #1;
            check({tag, ".r0_v_o"}, W'(ifc.r0_v_o), W'(!r1win));
            check({tag, ".r1_v_o"}, W'(ifc.r1_v_o), W'(r1win));
        end
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = mk("idle",      0,0,0,'0,'0,        0,0,0,'0,'0,          1,1,0,0,0, 0,0,'0);
        vecs[1]  = mk("r0_rd5",    1,0,5,'0,'0,        0,0,0,'0,'0,          1,0,1,0,5, 1,0,'0);
        vecs[2]  = mk("r1_wr9",    0,0,0,'0,'0,        1,1,9,W'(8'hA5),W'(8'h0F), 1,1,1,1,9, 0,0,'0);
        vecs[3]  = mk("r0_rd9",    1,0,9,'0,'0,        0,0,0,'0,'0,          1,0,1,0,9, 1,0,W'(8'h05));
        vecs[4]  = mk("r0_wr5",    1,1,5,W'(64'h1234_5678_9ABC_DEF0),ALL, 0,0,0,'0,'0, 1,0,1,1,5, 0,0,'0);
        vecs[5]  = mk("r1_rd5",    0,0,0,'0,'0,        1,0,5,'0,'0,          1,1,1,0,5, 0,1,W'(64'h1234_5678_9ABC_DEF0));
        vecs[6]  = mk("both_rd",   1,0,9,'0,'0,        1,0,5,'0,'0,          1,0,1,0,9, 1,0,W'(8'h05));
        vecs[7]  = mk("r1_rd9",    0,0,0,'0,'0,        1,0,9,'0,'0,          1,1,1,0,9, 0,1,W'(8'h05));
        vecs[8]  = mk("r0_wr9hi",  1,1,9,W'(8'hFF),W'(8'hF0), 0,0,0,'0,'0,   1,0,1,1,9, 0,0,'0);
        vecs[9]  = mk("r0_rd9b",   1,0,9,'0,'0,        0,0,0,'0,'0,          1,0,1,0,9, 1,0,W'(8'hF5));
        vecs[10] = mk("b2b_rd5",   1,0,5,'0,'0,        0,0,0,'0,'0,          1,0,1,0,5, 1,0,W'(64'h1234_5678_9ABC_DEF0));
        vecs[11] = mk("b2b_rd9",   1,0,9,'0,'0,        0,0,0,'0,'0,          1,0,1,0,9, 1,0,W'(8'hF5));

        drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
        repeat (2) @(posedge clk);
        do_reset();
        run_sweep(-1);

        for (int i = 0; i < 12; i++) apply(vecs[i]);
        starve_seq("starve1");

        // Build up two r1 losses, then reset while the third contested read is pending.
        for (int k = 0; k < 2; k++) apply(mk("contend", 1,0,9,'0,'0, 1,0,5,'0,'0, 1,0,1,0,9, 1,0,W'(8'hF5)));
        @(negedge clk);
        drive(1'b1, 1'b0, 6'd9, '0, '0, 1'b1, 1'b0, 6'd5, '0, '0);
        #1;
        check("prerst.r0_ready", W'(ifc.r0_ready_o), W'(1));
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        check("rdrst.r0_v_o", W'(ifc.r0_v_o), '0);
        check("rdrst.r1_v_o", W'(ifc.r1_v_o), '0);
        check("rdrst.mem_v", W'(ifc.mem_v_o), '0);
        do_reset();
        run_sweep(-1);
        starve_seq("starve2");

        do_reset();
        run_sweep(30);
        #2 rst_n = 1'b0;
        #1;
        check("midrst.mem_v", W'(ifc.mem_v_o), '0);
        check("midrst.mem_w", W'(ifc.mem_w_o), '0);
        check("midrst.init_done", W'(init_done), '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrel.mem_v", W'(ifc.mem_v_o), '0);
        run_sweep(-1);
        apply(mk("clr_rd9", 1,0,9,'0,'0, 0,0,0,'0,'0, 1,0,1,0,9, 1,0,'0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
